// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the memory-interface state encoding.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        DONE     = 3'd4
    } mem_state_t;

endpackage

// File: rtl/mdr_reg.sv
// Memory data register: loads from the internal bus or from RAM read data.
// A RAM capture always takes priority over a bus load on the same edge.
module mdr_reg #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_bus_load,
    input  logic              i_mem_load,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_mdr;

    // MDR update: memory capture first, then bus load, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mdr <= '0;
        end else if (i_mem_load) begin
            r_mdr <= i_mem_data;
        end else if (i_bus_load) begin
            r_mdr <= i_bus_data;
        end
    end

    assign o_q = r_mdr;

endmodule

// File: rtl/mem_interface.sv
// Memory-side datapath stage: MAR/MDR ownership and a four-phase handshake
// that turns level-held Read/Write into single-cycle RAM strobes.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (out-of-range MAR faults
// instead of wrapping; Mem_Fault stays 0 when the macro is undefined).
module mem_interface #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] MDR_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              Mem_Ready,
    output logic              Mem_Fault
);

    import cpu_pkg::*;

    localparam int               CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    mem_state_t        r_state;
    logic [DATA_W-1:0] r_mar;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fault;

    logic              w_mar_hi;
    logic              w_oob;
    logic              w_mdr_mem_load;
    logic              w_mdr_bus_load;

    // Upper MAR bits only matter when the bounds check is built in;
    // otherwise the address simply wraps modulo the RAM size.
    assign w_mar_hi = |r_mar[DATA_W-1:ADDR_W];
    assign w_oob    = w_mar_hi & BOUNDS_EN;

    // Capture RAM data on the last wait cycle; bus loads are blocked while a
    // read is in flight, except that a write accepted from IDLE takes the bus
    // value on its acceptance edge even if Read is also high.
    assign w_mdr_mem_load = (r_state == RD_WAIT) && (r_cnt == '0);
    assign w_mdr_bus_load = MDRin && (r_state != RD_WAIT) &&
                            (!Read || ((r_state == IDLE) && Write));

    // MAR loads from the bus in every state; ram_addr keeps its own copy.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_mar <= '0;
        end else if (MARin) begin
            r_mar <= BusMuxOut;
        end
    end

    // Transaction FSM with latched address, latency counter and sticky fault.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Read || Write) begin
                        r_addr <= r_mar[ADDR_W-1:0];
                        if (w_oob) begin
                            r_state <= DONE;
                            r_fault <= 1'b1;
                        end else if (Write) begin
                            r_state <= WR_ISSUE;
                        end else begin
                            r_state <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WR_ISSUE: begin
                    r_state <= DONE;
                end
                DONE: begin
                    if (!Read && !Write) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mdr_reg #(
        .DATA_W (DATA_W)
    ) u_mdr (
        .i_clk      (Clock),
        .i_rst_n    (Reset),
        .i_bus_data (BusMuxOut),
        .i_mem_data (ram_rdata),
        .i_bus_load (w_mdr_bus_load),
        .i_mem_load (w_mdr_mem_load),
        .o_q        (MDR_q)
    );

    // Strobes and ready decode straight from state, so reset clears them at once.
    assign ram_re    = (r_state == RD_ISSUE);
    assign ram_we    = (r_state == WR_ISSUE);
    assign Mem_Ready = (r_state == DONE);
    assign ram_addr  = r_addr;
    assign ram_wdata = MDR_q;
    assign Mem_Fault = r_fault;

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench: two DUTs (RD_LATENCY 1 and 3) share one stimulus stream.
module tb_mem_interface;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    localparam logic [31:0] JUNK = 32'h5A5A_0F0F;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] BusMuxOut;
    logic        MARin, MDRin, Read, Write;

    logic [31:0] mdr_1, wdata_1, rdata_1, mdr_3, wdata_3, rdata_3;
    logic [8:0]  addr_1, addr_3;
    logic        re_1, we_1, rdy_1, flt_1, re_3, we_3, rdy_3, flt_3;

    logic [31:0] ram [0:511];
    logic [31:0] p1_d;
    logic        p1_v = 1'b0;
    logic [31:0] p3_d [0:2];
    logic [2:0]  p3_v = 3'b000;

    // Bench-side reference state
    logic [31:0] ref_mem [0:511];
    logic [31:0] ref_mar, ref_mdr;
    logic        ref_fault;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    mem_interface #(.RD_LATENCY(1)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut), .MARin(MARin),
        .MDRin(MDRin), .Read(Read), .Write(Write), .MDR_q(mdr_1),
        .ram_addr(addr_1), .ram_wdata(wdata_1), .ram_re(re_1), .ram_we(we_1),
        .ram_rdata(rdata_1), .Mem_Ready(rdy_1), .Mem_Fault(flt_1));

    mem_interface #(.RD_LATENCY(3)) u_dut3 (
        .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut), .MARin(MARin),
        .MDRin(MDRin), .Read(Read), .Write(Write), .MDR_q(mdr_3),
        .ram_addr(addr_3), .ram_wdata(wdata_3), .ram_re(re_3), .ram_we(we_3),
        .ram_rdata(rdata_3), .Mem_Ready(rdy_3), .Mem_Fault(flt_3));

    // RAM device model: write from the latency-1 DUT, read pipelines per DUT.
    always @(posedge Clock) begin
        if (we_1) ram[addr_1] <= wdata_1;
        p1_v    <= re_1;
        p1_d    <= ram[addr_1];
        p3_v    <= {p3_v[1:0], re_3};
        p3_d[0] <= ram[addr_3];
        p3_d[1] <= p3_d[0];
        p3_d[2] <= p3_d[1];
    end
    assign rdata_1 = p1_v    ? p1_d    : JUNK;
    assign rdata_3 = p3_v[2] ? p3_d[2] : JUNK;

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mdr1"}, mdr_1, 32'h0);      chk({tag, "_mdr3"}, mdr_3, 32'h0);
        chk({tag, "_wd1"}, wdata_1, 32'h0);     chk({tag, "_wd3"}, wdata_3, 32'h0);
        chk({tag, "_addr1"}, 32'(addr_1), 0);   chk({tag, "_addr3"}, 32'(addr_3), 0);
        chk({tag, "_re1"}, 32'(re_1), 0);       chk({tag, "_re3"}, 32'(re_3), 0);
        chk({tag, "_we1"}, 32'(we_1), 0);       chk({tag, "_we3"}, 32'(we_3), 0);
        chk({tag, "_rdy1"}, 32'(rdy_1), 0);     chk({tag, "_rdy3"}, 32'(rdy_3), 0);
        chk({tag, "_flt1"}, 32'(flt_1), 0);     chk({tag, "_flt3"}, 32'(flt_3), 0);
    endtask

    task automatic set_mar(input logic [31:0] v);
        BusMuxOut = v; MARin = 1'b1;
        step;
        MARin = 1'b0; ref_mar = v;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        BusMuxOut = v; MDRin = 1'b1;
        step;
        MDRin = 1'b0; ref_mdr = v;
        chk("ld_mdr1", mdr_1, v);  chk("ld_mdr3", mdr_3, v);
        chk("ld_wd1", wdata_1, v); chk("ld_wd3", wdata_3, v);
        $display("load_mdr data=%h mdr1=%h mdr3=%h", v, mdr_1, mdr_3);
    endtask

    // Read with Read held for five edges; optionally reload MAR mid-flight.
    task automatic do_read(input bit marin_mid, input logic [31:0] mar_new);
        logic [8:0]  a;
        logic [31:0] val, old;
        bit          flt;
        a = ref_mar[8:0];
        flt = BOUNDS && (ref_mar[31:9] != 23'h0);
        val = ref_mem[a];
        old = ref_mdr;
        if (flt) ref_fault = 1'b1;
        Read = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step;
            chk("rd_re1", 32'(re_1), 32'(!flt && c == 0));
            chk("rd_re3", 32'(re_3), 32'(!flt && c == 0));
            chk("rd_we1", 32'(we_1), 0);
            chk("rd_we3", 32'(we_3), 0);
            chk("rd_rdy1", 32'(rdy_1), 32'(flt || c >= 2));
            chk("rd_rdy3", 32'(rdy_3), 32'(flt || c >= 4));
            chk("rd_mdr1", mdr_1, (!flt && c >= 2) ? val : old);
            chk("rd_mdr3", mdr_3, (!flt && c >= 4) ? val : old);
            chk("rd_flt1", 32'(flt_1), 32'(ref_fault));
            chk("rd_flt3", 32'(flt_3), 32'(ref_fault));
            if (!flt) begin
                chk("rd_addr1", 32'(addr_1), 32'(a));
                chk("rd_addr3", 32'(addr_3), 32'(a));
            end
            if (marin_mid && c == 1) begin BusMuxOut = mar_new; MARin = 1'b1; end
            if (marin_mid && c == 2) begin MARin = 1'b0; ref_mar = mar_new; end
        end
        Read = 1'b0;
        if (!flt) ref_mdr = val;
        step;
        chk("rd_fall1", 32'(rdy_1), 0);
        chk("rd_fall3", 32'(rdy_3), 0);
        $display("read addr=%h fault=%0d exp=%h mdr1=%h mdr3=%h", a, flt, ref_mdr, mdr_1, mdr_3);
    endtask

    // Write with same-cycle MDR load; 'both' also raises Read.
    task automatic do_write(input logic [31:0] data, input bit both);
        logic [8:0] a;
        bit         flt;
        a = ref_mar[8:0];
        flt = BOUNDS && (ref_mar[31:9] != 23'h0);
        if (flt) ref_fault = 1'b1;
        BusMuxOut = data; MDRin = 1'b1; Write = 1'b1; Read = both;
        step;
        MDRin = 1'b0;
        chk("wr_we1", 32'(we_1), 32'(!flt));  chk("wr_we3", 32'(we_3), 32'(!flt));
        chk("wr_re1", 32'(re_1), 0);          chk("wr_re3", 32'(re_3), 0);
        chk("wr_wd1", wdata_1, data);         chk("wr_wd3", wdata_3, data);
        chk("wr_rdy1", 32'(rdy_1), 32'(flt)); chk("wr_rdy3", 32'(rdy_3), 32'(flt));
        chk("wr_flt1", 32'(flt_1), 32'(ref_fault));
        if (!flt) begin
            chk("wr_addr1", 32'(addr_1), 32'(a));
            chk("wr_addr3", 32'(addr_3), 32'(a));
        end
        step;
        chk("wr_we1_off", 32'(we_1), 0);  chk("wr_re1_off", 32'(re_1), 0);
        chk("wr_re3_off", 32'(re_3), 0);
        chk("wr_rdy1_e1", 32'(rdy_1), 1); chk("wr_rdy3_e1", 32'(rdy_3), 1);
        Write = 1'b0; Read = 1'b0;
        step;
        chk("wr_fall1", 32'(rdy_1), 0);   chk("wr_fall3", 32'(rdy_3), 0);
        chk("wr_re1_end", 32'(re_1), 0);
        if (!flt) ref_mem[a] = data;
        ref_mdr = data;
        $display("write addr=%h data=%h both=%0d fault=%0d", a, data, both, flt);
    endtask

    initial begin
        logic [31:0] m, d;
        int          op;
        for (int i = 0; i < 512; i++) begin
            d = $urandom;
            ram[i] = d; ref_mem[i] = d;
        end
        ram[9'h075] = 32'hDEADBEEF; ref_mem[9'h075] = 32'hDEADBEEF;
        Reset = 1'b0; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
        ref_mar = '0; ref_mdr = '0; ref_fault = 1'b0;
        step; step;
        chk_idle_outputs("reset");
        Reset = 1'b1;
        step;

        set_mar(32'h0000_0075);
        do_read(1'b0, 32'h0);
        set_mar(32'h0000_0010);
        do_write(32'h1234_5678, 1'b0);
        do_read(1'b0, 32'h0);
        set_mar(32'h0000_0075);
        do_read(1'b1, 32'h0000_0020);
        do_read(1'b0, 32'h0);
        set_mar(32'h0000_0033);
        do_write(32'hCAFE_F00D, 1'b1);
        do_read(1'b0, 32'h0);
        set_mar(32'h0000_0200);
        do_read(1'b0, 32'h0);
        load_mdr(32'hA1B2_C3D4);

        for (int it = 0; it < 24; it++) begin
            m = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
            set_mar(m);
            op = $urandom_range(0, 3);
            case (op)
                0: do_read($urandom_range(0, 1) == 1, $urandom);
                1: do_write($urandom, 1'b0);
                2: do_write($urandom, 1'b1);
                default: load_mdr($urandom);
            endcase
        end

        // Reset asserted while both DUTs sit in RD_WAIT
        set_mar(32'h0000_0042);
        Read = 1'b1;
        step; step;
        #2 Reset = 1'b0;
        #1;
        Read = 1'b0;
        chk_idle_outputs("rst_mid");
        $display("reset mid-read asserted");
        step;
        Reset = 1'b1;
        ref_mar = '0; ref_mdr = '0; ref_fault = 1'b0;
        step;
        chk_idle_outputs("rst_rel");
        do_read(1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
